// File: rtl/revo_link_pkg.sv
// Shared revo link constants, state encoding and helpers for encoder and decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   REVO_MARKER_WORD  word sent on the link when a revolution occurs
//   REVO_NULL_WORD    idle word sent between revolutions
//   revo_state_e      decoder lock state
//   sat_inc16         16-bit saturating increment
package revo_link_pkg;

   localparam logic [7:0] REVO_MARKER_WORD = 8'b11001100;
   localparam logic [7:0] REVO_NULL_WORD   = 8'b00000000;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } revo_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/revo_pattern_finder.sv
// Finds the revo marker at any of the 8 bit alignments of a 2-word window.
// Latency: purely combinational.
// Backpressure: none; evaluates every cycle.
//
// Ports:
//   window_i  [15:0] {previous word, current word}, MSB first in time
//   found_o          marker present at some alignment
//   offset_o  [2:0]  lowest matching alignment k (marker at window_i[15-k -: 8])
module revo_pattern_finder
   import revo_link_pkg::*;
#(
   parameter logic [7:0] PATTERN = REVO_MARKER_WORD
) (
   input  logic [15:0] window_i,
   output logic        found_o,
   output logic [2:0]  offset_o
);

   // Scan from the highest offset down so the lowest matching offset is
   // the last one written and therefore wins.
   always_comb begin
      found_o  = 1'b0;
      offset_o = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (window_i[15-k -: 8] == PATTERN) begin
            found_o  = 1'b1;
            offset_o = k[2:0];
         end
      end
   end

endmodule

// File: rtl/revo_word_decoder.sv
// Locks onto the periodic revo marker in a deserialized word stream and flywheels the revo pulse.
// Latency: 1 word clock from the word that completes a marker to the registered outputs.
// Backpressure: none; one word is consumed every clock.
//
// Ports:
//   clock, reset         word clock; asynchronous active-high reset
//   word_in [7:0]        deserialized word, MSB first in time
//   revo_out             one-cycle revo pulse while locked
//   revo_synthetic       qualifies revo_out as flywheeled (marker missing)
//   locked               high while locked
//   bit_offset [2:0]     latched marker alignment
//   raw_match            marker seen at any alignment in the previous cycle
//   error_count [15:0]   saturating count of misplaced markers while locked
//   miss_count [1:0]     consecutive missing markers while locked
module revo_word_decoder
   import revo_link_pkg::*;
#(
   parameter logic [7:0] PATTERN         = REVO_MARKER_WORD,
   parameter int         EXPECTED_PERIOD = 1280,
   parameter int         CONFIRM_COUNT   = 3,
   parameter int         MISS_LIMIT      = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  word_in,
   output logic        revo_out,
   output logic        revo_synthetic,
   output logic        locked,
   output logic [2:0]  bit_offset,
   output logic        raw_match,
   output logic [15:0] error_count,
   output logic [1:0]  miss_count
);

   localparam int CNT_W  = $clog2(EXPECTED_PERIOD);
   localparam int CONF_W = $clog2(CONFIRM_COUNT + 1);

   localparam logic [CNT_W-1:0]  CNT_DUE   = CNT_W'(EXPECTED_PERIOD - 1);
   localparam logic [CONF_W-1:0] CONF_DONE = CONF_W'(CONFIRM_COUNT);
   localparam logic [1:0]        MISS_DROP = 2'(MISS_LIMIT);

   revo_state_e       state_q,   state_d;
   logic [7:0]        prev_word_q;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;
   logic [CONF_W-1:0] conf_q,    conf_d;
   logic [2:0]        offset_q,  offset_d;
   logic [1:0]        miss_q,    miss_d;
   logic [15:0]       err_q,     err_d;
   logic              revo_q,    revo_d;
   logic              synth_q,   synth_d;
   logic              locked_q;
   logic              raw_q;

   logic              found;
   logic [2:0]        found_off;
   logic              due;
   logic              at_off;

   revo_pattern_finder #(
      .PATTERN (PATTERN)
   ) u_finder (
      .window_i ({prev_word_q, word_in}),
      .found_o  (found),
      .offset_o (found_off)
   );

   assign due    = (cnt_q == CNT_DUE);
   assign at_off = found && (found_off == offset_q);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      conf_d   = conf_q;
      offset_d = offset_q;
      miss_d   = miss_q;
      err_d    = err_q;
      revo_d   = 1'b0;
      synth_d  = 1'b0;

      case (state_q)
         ST_SEARCH: begin
            cnt_d  = '0;
            conf_d = '0;
            miss_d = 2'd0;
            if (found) begin
               offset_d = found_off;
               conf_d   = CONF_W'(1);
               state_d  = ST_VERIFY;
            end
         end

         ST_VERIFY: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (at_off && due) begin
               cnt_d  = '0;
               conf_d = conf_q + CONF_W'(1);
               if (conf_q + CONF_W'(1) == CONF_DONE) begin
                  state_d = ST_LOCKED;
                  revo_d  = 1'b1;
                  miss_d  = 2'd0;
               end
            end else if (found || due) begin
               // Early marker, wrong alignment or missing marker: start over.
               // A marker on this word is deliberately not used as a new seed.
               state_d = ST_SEARCH;
               cnt_d   = '0;
               conf_d  = '0;
            end
         end

         ST_LOCKED: begin
            cnt_d = due ? '0 : cnt_q + CNT_W'(1);
            // Anything other than the on-time marker at the locked alignment
            // is counted and otherwise ignored; phase stays as it was.
            if (found && !(due && at_off)) begin
               err_d = sat_inc16(err_q);
            end
            if (due) begin
               if (at_off) begin
                  revo_d = 1'b1;
                  miss_d = 2'd0;
               end else if (miss_q + 2'd1 == MISS_DROP) begin
                  // Too many consecutive misses: drop lock without a pulse.
                  state_d = ST_SEARCH;
                  miss_d  = 2'd0;
                  conf_d  = '0;
               end else begin
                  revo_d  = 1'b1;
                  synth_d = 1'b1;
                  miss_d  = miss_q + 2'd1;
               end
            end
         end

         default: begin
            state_d = ST_SEARCH;
            cnt_d   = '0;
            conf_d  = '0;
            miss_d  = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_SEARCH;
         prev_word_q <= 8'd0;
         cnt_q       <= '0;
         conf_q      <= '0;
         offset_q    <= 3'd0;
         miss_q      <= 2'd0;
         err_q       <= 16'd0;
         revo_q      <= 1'b0;
         synth_q     <= 1'b0;
         locked_q    <= 1'b0;
         raw_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         prev_word_q <= word_in;
         cnt_q       <= cnt_d;
         conf_q      <= conf_d;
         offset_q    <= offset_d;
         miss_q      <= miss_d;
         err_q       <= err_d;
         revo_q      <= revo_d;
         synth_q     <= synth_d;
         locked_q    <= (state_d == ST_LOCKED);
         raw_q       <= found;
      end
   end

   assign revo_out       = revo_q;
   assign revo_synthetic = synth_q;
   assign locked         = locked_q;
   assign bit_offset     = offset_q;
   assign raw_match      = raw_q;
   assign error_count    = err_q;
   assign miss_count     = miss_q;

endmodule

// File: tb/tb_revo_word_decoder.sv
// Self-checking bench for revo_word_decoder: directed lock/flywheel/error scenarios
// followed by randomized marker streams, all checked every cycle against a
// reference model that tracks phase as elapsed cycles since the last anchor.
module tb_revo_word_decoder;

   localparam int         P   = 16;
   localparam int         C   = 3;
   localparam int         ML  = 2;
   localparam logic [7:0] PAT = 8'b11001100;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  word_in = 8'd0;
   logic        revo_out;
   logic        revo_synthetic;
   logic        locked;
   logic [2:0]  bit_offset;
   logic        raw_match;
   logic [15:0] error_count;
   logic [1:0]  miss_count;

   int total = 0;
   int bad   = 0;

   // reference model state
   int         m_mode;   // 0 search, 1 verify, 2 locked
   int         m_cyc;
   int         m_last;   // cycle of last accepted marker / flywheel point
   int         m_conf;
   int         m_miss;
   int         m_off;
   int         m_err;
   logic [7:0] m_prev;
   logic       e_revo, e_syn, e_raw;

   // observation counters
   int pulses = 0;
   int synths = 0;
   bit saw_lock = 1'b0;
   int p0, s0;

   always #5 clock = ~clock;

   revo_word_decoder #(
      .PATTERN         (PAT),
      .EXPECTED_PERIOD (P),
      .CONFIRM_COUNT   (C),
      .MISS_LIMIT      (ML)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .word_in        (word_in),
      .revo_out       (revo_out),
      .revo_synthetic (revo_synthetic),
      .locked         (locked),
      .bit_offset     (bit_offset),
      .raw_match      (raw_match),
      .error_count    (error_count),
      .miss_count     (miss_count)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_conf = 0; m_miss = 0; m_off = 0; m_err = 0;
      m_prev = 8'd0; m_last = 0; m_cyc = 0;
      e_revo = 1'b0; e_syn = 1'b0; e_raw = 1'b0;
   endtask

   task automatic model_step(input logic [7:0] w);
      logic [15:0] win;
      bit f, due, good;
      int k;
      win = {m_prev, w};
      f = 1'b0;
      k = 0;
      for (int i = 0; i < 8; i++) begin
         if (!f && ((win >> (8 - i)) & 16'h00FF) == {8'h00, PAT}) begin
            f = 1'b1;
            k = i;
         end
      end
      m_prev = w;
      e_raw  = f;
      e_revo = 1'b0;
      e_syn  = 1'b0;
      due  = ((m_cyc - m_last) == P);
      good = f && (k == m_off);
      case (m_mode)
         0: begin
            if (f) begin
               m_off = k; m_last = m_cyc; m_conf = 1; m_mode = 1;
            end
         end
         1: begin
            if (good && due) begin
               m_conf++;
               m_last = m_cyc;
               if (m_conf == C) begin
                  m_mode = 2; e_revo = 1'b1; m_miss = 0;
               end
            end else if (f || due) begin
               m_mode = 0; m_conf = 0;
            end
         end
         default: begin
            if (f && !(due && good) && m_err < 65535) m_err++;
            if (due) begin
               m_last = m_cyc;
               if (good) begin
                  e_revo = 1'b1; m_miss = 0;
               end else if (m_miss + 1 >= ML) begin
                  m_mode = 0; m_miss = 0; m_conf = 0;
               end else begin
                  m_miss++; e_revo = 1'b1; e_syn = 1'b1;
               end
            end
         end
      endcase
      m_cyc++;
   endtask

   // Drive one word, let the DUT and model consume it, compare at the negedge.
   task automatic step(input logic [7:0] w);
      word_in = w;
      @(posedge clock);
      model_step(w);
      @(negedge clock);
      chk("revo_out",       revo_out,       e_revo);
      chk("revo_synthetic", revo_synthetic, e_syn);
      chk("locked",         locked,         (m_mode == 2));
      chk("bit_offset",     bit_offset,     m_off);
      chk("raw_match",      raw_match,      e_raw);
      chk("error_count",    error_count,    m_err);
      chk("miss_count",     miss_count,     m_miss);
      if (revo_out) pulses++;
      if (revo_synthetic) synths++;
      if (locked) saw_lock = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(8'd0);
   endtask

   // One nominal 16-word period with the marker at alignment k (or dropped).
   task automatic period(input int k, input bit drop);
      logic [15:0] m;
      m = {PAT, 8'h00} >> k;
      if (drop) begin
         step(8'd0); step(8'd0);
      end else begin
         step(m[15:8]); step(m[7:0]);
      end
      idle(P - 2);
   endtask

   // Asynchronous reset asserted between clock edges; outputs must clear at once.
   task automatic do_reset();
      #2 reset = 1'b1;
      #1;
      chk("rst_revo_out",    revo_out,       0);
      chk("rst_synthetic",   revo_synthetic, 0);
      chk("rst_locked",      locked,         0);
      chk("rst_bit_offset",  bit_offset,     0);
      chk("rst_raw_match",   raw_match,      0);
      chk("rst_error_count", error_count,    0);
      chk("rst_miss_count",  miss_count,     0);
      model_reset();
      @(negedge clock);
      reset = 1'b0;
   endtask

   logic [7:0]  wa [0:16];
   logic [15:0] mk;
   int rk, len, pos;

   initial begin
      model_reset();
      reset   = 1'b1;
      word_in = 8'd0;
      repeat (2) @(negedge clock);
      chk("init_revo_out",    revo_out,       0);
      chk("init_locked",      locked,         0);
      chk("init_bit_offset",  bit_offset,     0);
      chk("init_raw_match",   raw_match,      0);
      chk("init_error_count", error_count,    0);
      chk("init_miss_count",  miss_count,     0);
      reset = 1'b0;

      // aligned lock
      idle(3);
      repeat (3) period(0, 1'b0);
      chk("aligned_locked", locked, 1);
      chk("aligned_offset", bit_offset, 0);
      p0 = pulses; s0 = synths;
      repeat (4) period(0, 1'b0);
      chk("aligned_pulses", pulses - p0, 4);
      chk("aligned_synth",  synths - s0, 0);

      // flywheel over a single dropped marker
      p0 = pulses; s0 = synths;
      period(0, 1'b1);
      chk("fly_miss1",   miss_count, 1);
      chk("fly_pulse",   pulses - p0, 1);
      chk("fly_synth",   synths - s0, 1);
      period(0, 1'b0);
      chk("fly_miss0",   miss_count, 0);
      chk("fly_locked",  locked, 1);
      chk("fly_synth2",  synths - s0, 1);

      // loss of lock on two consecutive drops, then re-lock
      p0 = pulses; s0 = synths;
      period(0, 1'b1);
      period(0, 1'b1);
      chk("loss_unlocked", locked, 0);
      chk("loss_pulses",   pulses - p0, 1);
      chk("loss_synth",    synths - s0, 1);
      repeat (3) period(0, 1'b0);
      chk("relock", locked, 1);

      // spurious marker at counter 7
      p0 = pulses;
      step(PAT); idle(7); step(PAT); idle(7);
      chk("spur_errors", error_count, 1);
      chk("spur_pulses", pulses - p0, 1);
      period(0, 1'b0);
      chk("spur_pulses2", pulses - p0, 2);
      chk("spur_locked",  locked, 1);

      // asynchronous reset mid-period while locked
      idle(5);
      do_reset();

      // misaligned lock at k=5
      idle(2);
      step(8'b00000110);
      chk("k5_raw_before", raw_match, 0);
      step(8'b01100000);
      chk("k5_raw_after", raw_match, 1);
      idle(P - 2);
      repeat (2) period(5, 1'b0);
      chk("k5_locked", locked, 1);
      chk("k5_offset", bit_offset, 5);

      // early second marker aborts verification
      do_reset();
      saw_lock = 1'b0;
      idle(2);
      step(PAT); idle(14); step(PAT); idle(40);
      chk("abort_no_lock", saw_lock, 0);

      // randomized marker streams
      rk = $urandom_range(0, 7);
      for (int it = 0; it < 150; it++) begin
         if ($urandom_range(0, 9) == 0) rk = $urandom_range(0, 7);
         len = P;
         case ($urandom_range(0, 19))
            0:       len = P - 1;
            1:       len = P + 1;
            default: len = P;
         endcase
         for (int i = 0; i < 17; i++) wa[i] = 8'd0;
         mk = {PAT, 8'h00} >> rk;
         if ($urandom_range(0, 5) != 0) begin
            wa[0] = mk[15:8];
            wa[1] = mk[7:0];
         end
         if ($urandom_range(0, 7) == 0) begin
            pos = $urandom_range(3, len - 3);
            wa[pos]     = mk[15:8];
            wa[pos + 1] = mk[7:0];
         end
         if ($urandom_range(0, 11) == 0) begin
            pos = $urandom_range(2, len - 1);
            wa[pos] = 8'($urandom);
         end
         for (int i = 0; i < len; i++) step(wa[i]);
         if ($urandom_range(0, 39) == 0) do_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
